// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM
// state encodings, ALU operation classes, trap causes and the level-control
// bundle produced by the opcode decoder.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // ALU operation classes, zero-extended to ALUOP_W at the top level.
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_RTYPE  = 2'd2;
  localparam logic [1:0] ALU_ITYPE  = 2'd3;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } opc_class_t;

  // Level controls that depend only on the registered opcode.
  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrc1;
    logic       aluSrc2;
    logic       lui;
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memWrite;
  } ctrl_lvl_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: maps a 7-bit RV32I opcode to its class, a
// legality flag and the level-control bundle used by EXEC/MEM/WB outputs.
module ctrl_opcode_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0]  opcode,
  output opc_class_t  opcClass,
  output logic        legal,
  output ctrl_lvl_t   lvl
);

  // Decode table; anything outside the supported opcode set is illegal.
  always_comb begin
    opcClass = CLS_ILLEGAL;
    legal    = 1'b1;
    lvl      = '0;
    case (opcode)
      OPC_RTYPE: begin
        opcClass  = CLS_RTYPE;
        lvl.aluOp = ALU_RTYPE;
      end
      OPC_ITYPE: begin
        opcClass    = CLS_ITYPE;
        lvl.aluOp   = ALU_ITYPE;
        lvl.aluSrc2 = 1'b1;
      end
      OPC_LOAD: begin
        opcClass    = CLS_LOAD;
        lvl.aluOp   = ALU_ADD;
        lvl.aluSrc2 = 1'b1;
        lvl.memRead = 1'b1;
      end
      OPC_STORE: begin
        opcClass     = CLS_STORE;
        lvl.aluOp    = ALU_ADD;
        lvl.aluSrc2  = 1'b1;
        lvl.memWrite = 1'b1;
      end
      OPC_BRANCH: begin
        opcClass   = CLS_BRANCH;
        lvl.aluOp  = ALU_BRANCH;
        lvl.branch = 1'b1;
      end
      OPC_LUI: begin
        opcClass    = CLS_LUI;
        lvl.lui     = 1'b1;
        lvl.aluSrc2 = 1'b1;
      end
      OPC_AUIPC: begin
        opcClass    = CLS_AUIPC;
        lvl.aluSrc1 = 1'b1;
        lvl.aluSrc2 = 1'b1;
      end
      OPC_JAL: begin
        opcClass    = CLS_JAL;
        lvl.aluSrc1 = 1'b1;
        lvl.aluSrc2 = 1'b1;
        lvl.jump    = 1'b1;
      end
      OPC_JALR: begin
        opcClass    = CLS_JALR;
        lvl.aluSrc2 = 1'b1;
        lvl.jump    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory
// handshakes, stall, illegal-opcode trap and a retired-instruction counter.
// Optional MEM wait timeout enabled by defining CTRL_MEM_TIMEOUT_EN.
//
// Handshake: the FSM advances only on a cycle where iStall is low; an
// iInstrAck/iMemAck seen while stalled is dropped and must be re-presented.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int RETIRE_W = 32
`ifdef CTRL_MEM_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 16
`endif
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [6:0]          iOpcode,
  input  logic                iInstrAck,
  input  logic                iMemAck,
  input  logic                iStall,
  output logic                oInstrReq,
  output logic                oIrWr,
  output logic                oPcWr,
  output logic                oPcSrc,
  output logic                oMemRd,
  output logic                oMemWr,
  output logic [ALUOP_W-1:0]  oAluOp,
  output logic                oAluSrc1,
  output logic                oAluSrc2,
  output logic                oMemtoReg,
  output logic                oRegWrite,
  output logic                oLui,
  output logic                oBranch,
  output logic                oJump,
  output logic                oTrap,
  output logic [1:0]          oTrapCause,
  output logic [2:0]          oState,
  output logic [RETIRE_W-1:0] oRetired
);

  state_t              stateQ, stateD;
  logic [6:0]          opcodeQ;
  logic [1:0]          trapCauseQ, trapCauseD;
  logic [RETIRE_W-1:0] retiredQ;
  logic                runQ;
  opc_class_t          opcClass;
  logic                opcLegal;
  ctrl_lvl_t           lvl;
  logic                advance;
  logic                instrTake;
  logic                retire;
  logic                memTimeout;

  ctrl_opcode_decode uDecode (
    .opcode   (opcodeQ),
    .opcClass (opcClass),
    .legal    (opcLegal),
    .lvl      (lvl)
  );

  // runQ keeps every output low until the first clock after reset release.
  assign advance   = runQ && !iStall && (stateQ != ST_TRAP);
  assign instrTake = advance && (stateQ == ST_FETCH) && iInstrAck;
  assign retire    = advance && (stateD == ST_FETCH) &&
                     (stateQ == ST_EXEC || stateQ == ST_MEM || stateQ == ST_WB);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  logic [WAIT_W-1:0] waitQ;

  assign memTimeout = (waitQ == WAIT_W'(MEM_TIMEOUT - 1));

  // Count un-acked MEM cycles; cleared whenever the FSM is outside MEM.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      waitQ <= '0;
    end else if (advance) begin
      if (stateQ != ST_MEM) waitQ <= '0;
      else if (!iMemAck)    waitQ <= waitQ + WAIT_W'(1);
    end
  end
`else
  assign memTimeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) stateQ <= ST_FETCH;
    else      stateQ <= stateD;
  end

  // Opcode, trap cause, retire counter and run flag.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      runQ       <= 1'b0;
      opcodeQ    <= '0;
      trapCauseQ <= CAUSE_NONE;
      retiredQ   <= '0;
    end else begin
      runQ       <= 1'b1;
      trapCauseQ <= trapCauseD;
      if (instrTake) opcodeQ  <= iOpcode;
      if (retire)    retiredQ <= retiredQ + RETIRE_W'(1);
    end
  end

  // Next-state and trap-cause selection.
  always_comb begin
    stateD     = stateQ;
    trapCauseD = trapCauseQ;
    if (advance) begin
      case (stateQ)
        ST_FETCH: if (iInstrAck) stateD = ST_DECODE;
        ST_DECODE: begin
          if (opcLegal) begin
            stateD = ST_EXEC;
          end else begin
            stateD     = ST_TRAP;
            trapCauseD = CAUSE_ILLEGAL;
          end
        end
        ST_EXEC: begin
          case (opcClass)
            CLS_LOAD, CLS_STORE: stateD = ST_MEM;
            CLS_BRANCH:          stateD = ST_FETCH;
            default:             stateD = ST_WB;
          endcase
        end
        ST_MEM: begin
          if (iMemAck) begin
            stateD = lvl.memRead ? ST_WB : ST_FETCH;
          end else if (memTimeout) begin
            stateD     = ST_TRAP;
            trapCauseD = CAUSE_MEM_TIMEOUT;
          end
        end
        ST_WB:   stateD = ST_FETCH;
        default: stateD = stateQ;
      endcase
    end
  end

  // Datapath strobes from state and registered opcode; one-cycle strobes
  // are suppressed while stalled, levels are left alone.
  always_comb begin
    oInstrReq  = 1'b0;
    oIrWr      = 1'b0;
    oPcWr      = 1'b0;
    oPcSrc     = 1'b0;
    oMemRd     = 1'b0;
    oMemWr     = 1'b0;
    oAluOp     = '0;
    oAluSrc1   = 1'b0;
    oAluSrc2   = 1'b0;
    oMemtoReg  = 1'b0;
    oRegWrite  = 1'b0;
    oLui       = 1'b0;
    oBranch    = 1'b0;
    oJump      = 1'b0;
    oTrap      = 1'b0;
    oTrapCause = CAUSE_NONE;
    case (stateQ)
      ST_FETCH: begin
        oInstrReq = runQ;
        if (instrTake) begin
          oIrWr = 1'b1;
          oPcWr = 1'b1;
        end
      end
      ST_EXEC: begin
        oAluOp   = ALUOP_W'(lvl.aluOp);
        oAluSrc1 = lvl.aluSrc1;
        oAluSrc2 = lvl.aluSrc2;
        oLui     = lvl.lui;
        oBranch  = lvl.branch;
        if (lvl.branch) begin
          oPcSrc = 1'b1;
          oPcWr  = !iStall;
        end
      end
      ST_MEM: begin
        oMemRd   = lvl.memRead;
        oMemWr   = lvl.memWrite;
        oAluSrc2 = 1'b1;
      end
      ST_WB: begin
        oRegWrite = !iStall;
        oMemtoReg = lvl.memRead;
        if (lvl.jump) begin
          oJump  = 1'b1;
          oPcSrc = 1'b1;
          oPcWr  = !iStall;
        end
      end
      ST_TRAP: begin
        oTrap      = 1'b1;
        oTrapCause = trapCauseQ;
      end
      default: ;
    endcase
  end

  assign oState   = stateQ;
  assign oRetired = retiredQ;

endmodule
